// File: rtl/ula_pkg.sv
// ula_pkg: shared widths, ULA opcodes and the arbiter state type.
// Build option ULA_ARB_FIXED_PRIO_EN selects fixed-priority arbitration
// (see ula_rr_pick); this package is unaffected by it.
package ula_pkg;

  localparam int ULA_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ula.sv
// ula: the shared combinational 16-bit ALU (A, B, op -> C).
// Overflow and borrow simply wrap; no flags are produced.
module ula
  import ula_pkg::*;
#(
  parameter int W = ULA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_c
);

  // Pure combinational operation select.
  always_comb begin
    o_c = '0;
    case (i_op)
      OP_ADD:  o_c = i_a + i_b;
      OP_SUB:  o_c = i_a - i_b;
      OP_AND:  o_c = i_a & i_b;
      OP_OR:   o_c = i_a | i_b;
      default: o_c = '0;
    endcase
  end

endmodule

// File: rtl/ula_rr_pick.sv
// ula_rr_pick: combinational winner selection over a request vector.
// Default: first valid index at or after i_ptr, wrapping around.
// With ULA_ARB_FIXED_PRIO_EN defined: lowest valid index wins, i_ptr ignored.
module ula_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  int             w_cand;
  logic [IDW-1:0] w_cand_idx;
  logic           w_found;

  // Scan candidates in priority order; the first valid one takes the grant.
  always_comb begin
    o_grant    = '0;
    o_idx      = '0;
    w_found    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      w_cand = k;
`else
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
`endif
      w_cand_idx = IDW'(w_cand);
      if (!w_found && i_valid[w_cand_idx]) begin
        w_found             = 1'b1;
        o_grant[w_cand_idx] = 1'b1;
        o_idx               = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one ULA among NREQ requesters.
// Flow per operation: IDLE (grant + latch operands) -> EXEC (ULA settles,
// capture C) -> RESP (hold result until rsp_ready) -> IDLE.
// Build option ULA_ARB_FIXED_PRIO_EN: fixed priority, no round-robin pointer.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int          W        = ULA_W,
  parameter int          IDW      = $clog2(NREQ),
  // Counter start value after reset; 0 for normal use.
  parameter logic [15:0] OPS_INIT = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic [W-1:0]    ula_a,
  output logic [W-1:0]    ula_b,
  output logic [1:0]      ula_op,
  input  logic [W-1:0]    ula_c,
  output logic            busy,
  output logic [15:0]     ops_done
);

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_ula_a;
  logic [W-1:0]    r_ula_b;
  logic [1:0]      r_ula_op;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_data;
  logic            r_rsp_valid;
  logic [15:0]     r_ops_done;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_ptr;
  logic            w_any;
  logic            w_accept;
  logic            w_release;

  logic [W-1:0]    w_a_arr  [NREQ];
  logic [W-1:0]    w_b_arr  [NREQ];
  logic [1:0]      w_op_arr [NREQ];

  // Unpack the flat request buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a_arr[gi]  = req_a[gi*W +: W];
    assign w_b_arr[gi]  = req_b[gi*W +: W];
    assign w_op_arr[gi] = req_op[gi*2 +: 2];
  end

`ifdef ULA_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDW-1:0] r_ptr;
  assign w_ptr = r_ptr;

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_release) begin
      r_ptr <= (r_rsp_id == IDW'(NREQ - 1)) ? '0 : r_rsp_id + 1'b1;
    end
  end
`endif

  ula_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_any     = |req_valid;
  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_release = (r_state == RESP) && rsp_ready;

  // Grant is visible only while idle and out of reset, so reset forces it low.
  assign req_ready = ((r_state == IDLE) && rst_n) ? w_grant : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = EXEC;
      EXEC:    w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch on accept, result capture in EXEC, completion count on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ula_a     <= '0;
      r_ula_b     <= '0;
      r_ula_op    <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_ops_done  <= OPS_INIT;
    end else begin
      if (w_accept) begin
        r_ula_a  <= w_a_arr[w_idx];
        r_ula_b  <= w_b_arr[w_idx];
        r_ula_op <= w_op_arr[w_idx];
        r_rsp_id <= w_idx;
      end
      if (r_state == EXEC) begin
        r_rsp_data  <= ula_c;
        r_rsp_valid <= 1'b1;
      end
      if (w_release) begin
        r_rsp_valid <= 1'b0;
        r_ops_done  <= r_ops_done + 16'd1;
      end
    end
  end

  assign ula_a     = r_ula_a;
  assign ula_b     = r_ula_b;
  assign ula_op    = r_ula_op;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = r_rsp_valid;
  assign busy      = (r_state != IDLE);
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model. Honours ULA_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_ula_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic            rsp_valid, rsp_ready, busy;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data, ula_a, ula_b, ula_c;
  logic [1:0]      ula_op;
  logic [15:0]     ops_done;

  // Second instance whose counter starts at 0xFFFF, for the wrap check.
  logic [NREQ-1:0] wr_valid, wr_ready;
  logic [NREQ*W-1:0] wr_a, wr_b;
  logic [NREQ*2-1:0] wr_op;
  logic            wr_rsp_valid, wr_rsp_ready, wr_busy;
  logic [1:0]      wr_rsp_id, wr_ula_op;
  logic [W-1:0]    wr_rsp_data, wr_ula_a, wr_ula_b, wr_ula_c;
  logic [15:0]     wr_ops_done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ula_arbiter #(.NREQ(NREQ), .W(W), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .ula_a(ula_a),
    .ula_b(ula_b), .ula_op(ula_op), .ula_c(ula_c), .busy(busy), .ops_done(ops_done)
  );
  ula u_ula (.i_a(ula_a), .i_b(ula_b), .i_op(ula_op), .o_c(ula_c));

  ula_arbiter #(.NREQ(NREQ), .W(W), .IDW(2), .OPS_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(wr_valid), .req_ready(wr_ready),
    .req_a(wr_a), .req_b(wr_b), .req_op(wr_op), .rsp_valid(wr_rsp_valid),
    .rsp_ready(wr_rsp_ready), .rsp_id(wr_rsp_id), .rsp_data(wr_rsp_data),
    .ula_a(wr_ula_a), .ula_b(wr_ula_b), .ula_op(wr_ula_op), .ula_c(wr_ula_c),
    .busy(wr_busy), .ops_done(wr_ops_done)
  );
  ula u_ula_wrap (.i_a(wr_ula_a), .i_b(wr_ula_b), .i_op(wr_ula_op), .o_c(wr_ula_c));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      if (v[k]) return k;
`else
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    end
    return -1;
  endfunction

  function automatic logic [15:0] calc(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int unsigned r;
    case (op)
      2'd0: r = int'(a) + int'(b);
      2'd1: r = 32'h10000 + int'(a) - int'(b);
      2'd2: r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return r[15:0];
  endfunction

  bit          m_busy;
  int          m_age, m_ptr, m_id, m_pick, m_txn;
  logic [15:0] m_a, m_b, m_data, m_done;
  logic [1:0]  m_op;

  always_comb m_pick = pick(req_valid, m_ptr);

  // Model: one transaction in flight; age counts edges since its grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_ptr <= 0; m_id <= 0;
      m_a <= '0; m_b <= '0; m_op <= '0; m_data <= '0; m_done <= '0;
    end else if (!m_busy) begin
      if (req_valid != 0) begin
        m_busy <= 1'b1; m_age <= 1; m_id <= m_pick;
        m_a  <= req_a[m_pick*W +: W];
        m_b  <= req_b[m_pick*W +: W];
        m_op <= req_op[m_pick*2 +: 2];
      end
    end else if (m_age == 1) begin
      m_age  <= 2;
      m_data <= calc(m_a, m_b, m_op);
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
      m_done <= m_done + 16'd1;
      m_ptr  <= (m_id + 1) % NREQ;
      m_txn  <= m_txn + 1;
      $display("txn %0d: id=%0d a=%h b=%h op=%0d c=%h", m_txn, m_id, m_a, m_b, m_op, m_data);
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] exp_ready;
      exp_ready = '0;
      if (rst_n && !m_busy && req_valid != 0) exp_ready[m_pick] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, m_busy && m_age == 2);
      check("rsp_id",    rsp_id, m_id[1:0]);
      check("rsp_data",  rsp_data, m_data);
      check("ula_ops",   {ula_a, ula_b, ula_op}, {m_a, m_b, m_op});
      check("busy",      busy, m_busy);
      check("ops_done",  ops_done, m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic wait_rsp_valid(input int lim);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", rsp_valid, 1'b1);
  endtask

  int g_idx [5];
  int g_cyc [5];
  int g_n;
`ifdef ULA_ARB_FIXED_PRIO_EN
  int exp_g [5] = '{0, 0, 0, 0, 0};
  logic [3:0] exp_bp_grant = 4'b0001;
`else
  int exp_g [5] = '{0, 1, 2, 3, 0};
  logic [3:0] exp_bp_grant = 4'b0100;
`endif

  initial begin
    logic [15:0] held_data;
    int wn;
    rst_n = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b0; m_txn = 0;
    wr_valid = '0; wr_a = '0; wr_b = '0; wr_op = '0; wr_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1. reset with all requests asserted
    @(negedge clk);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_ops_done", ops_done, 16'h0000);
    check("rst_busy", busy, 1'b0);

    // 2. single ADD from requester 0
    drive_edge();
    rst_n = 1'b1; req_valid = 4'b0001; set_req(0, 16'h0003, 16'h0004, 2'b00); rsp_ready = 1'b1;
    @(negedge clk);
    check("single_grant", req_ready, 4'b0001);
    drive_edge();
    req_valid = 4'b0000;
    @(negedge clk);
    check("single_exec_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_id", rsp_id, 2'd0);
    check("single_rsp_data", rsp_data, 16'h0007);
    @(negedge clk);
    check("single_ops_done", ops_done, 16'h0001);

    // 3. all requesters valid from reset, rsp_ready tied high
    drive_edge(); rst_n = 1'b0;
    drive_edge(); rst_n = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i * 16'h0101), 16'h0010, 2'(i));
    g_n = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (req_ready != 0 && g_n < 5) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g_idx[g_n] = k;
        g_cyc[g_n] = c;
        g_n++;
      end
    end
    check("rr_grant_count", g_n, 5);
    for (int k = 0; k < 5; k++) begin
      check("rr_grant_order", g_idx[k], exp_g[k]);
      check("rr_grant_cycle", g_cyc[k], 3 * k);
    end
    drive_edge(); req_valid = 4'b0000;
    repeat (4) drive_edge();

    // 4. backpressure: hold the response for 5 cycles
    rsp_ready = 1'b0; req_valid = 4'b0010; set_req(1, 16'h1234, 16'h0034, 2'b01);
    wait_rsp_valid(6);
    check("bp_rsp_id", rsp_id, 2'd1);
    check("bp_rsp_data", rsp_data, 16'h1200);
    held_data = rsp_data;
    drive_edge(); req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_data", rsp_data, held_data);
      check("bp_hold_id", rsp_id, 2'd1);
      check("bp_no_grant", req_ready, 4'b0000);
    end
    drive_edge(); rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_no_grant", req_ready, 4'b0000);
    @(negedge clk);
    check("bp_next_grant", req_ready, exp_bp_grant);
    drive_edge(); req_valid = 4'b0000;
    repeat (4) drive_edge();

    // 5. result wrap and counter wrap
    req_valid = 4'b0100; set_req(2, 16'hFFFF, 16'h0001, 2'b00);
    wait_rsp_valid(6);
    check("wrap_rsp_id", rsp_id, 2'd2);
    check("wrap_rsp_data", rsp_data, 16'h0000);
    drive_edge(); req_valid = 4'b0000;
    check("cnt_preload", wr_ops_done, 16'hFFFF);
    wr_valid = 4'b0001;
    wn = 0;
    @(negedge clk);
    while (!wr_rsp_valid && wn < 8) begin @(negedge clk); wn++; end
    check("cnt_wait", wr_rsp_valid, 1'b1);
    drive_edge(); wr_valid = 4'b0000;
    @(negedge clk);
    check("cnt_wrap", wr_ops_done, 16'h0000);
    repeat (4) drive_edge();

    // 6. reset while in EXEC aborts the operation
    req_valid = 4'b0001; set_req(0, 16'h0005, 16'h0002, 2'b01); rsp_ready = 1'b1;
    @(negedge clk);
    check("abort_grant", req_ready, 4'b0001);
    drive_edge(); rst_n = 1'b0; req_valid = 4'b0000;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    drive_edge(); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    drive_edge(); req_valid = 4'b1000; set_req(3, 16'h0F0F, 16'h00FF, 2'b10);
    wait_rsp_valid(6);
    check("after_abort_id", rsp_id, 2'd3);
    check("after_abort_data", rsp_data, 16'h000F);
    drive_edge(); req_valid = 4'b0000;

    // Randomized traffic; the per-cycle compare checks everything.
    repeat (400) begin
      drive_edge();
      req_valid = 4'($urandom_range(0, 15));
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      req_op    = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drive_edge(); req_valid = 4'b0000; rsp_ready = 1'b1;
    repeat (5) drive_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
